cnn_window_gen: RTL and testbench

CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

---
 rtl/cnn_window_gen.sv | 165 ++++++++++++++++
 tb/tb_cnn_window_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: builds a sliding 3x3 pixel window from a raster-order pixel
// stream for a CNN kernel MAC. Two line buffers hold the previous two rows;
// a 3x3 register window shifts one column left on every accepted pixel.
// One window is produced per accepted pixel once at least KY rows and KX
// columns have been seen (stride 1, no padding).
module cnn_window_gen #(
   parameter int KX     = 3,
   parameter int KY     = 3,
   parameter int I_F_BW = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_soft_reset,
   input  logic                        i_run,
   input  logic                        i_in_valid,
   input  logic [I_F_BW-1:0]           i_in_pixel,
   output logic                        o_in_ready,
   output logic                        o_ot_valid,
   output logic [KX*KY*I_F_BW-1:0]     o_ot_fmap,
   output logic                        o_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(KX - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(KY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       col;
   logic [RW-1:0]       row;
   logic                accept;
   logic                last_pix;

   // Line buffers: lb_top holds row-2, lb_mid holds row-1.
   logic [I_F_BW-1:0]   lb_top [IMG_W];
   logic [I_F_BW-1:0]   lb_mid [IMG_W];

   // Window registers: win[ky][kx], ky=0 oldest row, kx=0 leftmost column.
   logic [I_F_BW-1:0]   win [KY][KX];

   assign o_in_ready = (state == ST_RUN);
   assign o_done     = (state == ST_DONE);
   // Soft reset takes priority over a pixel presented on the same edge.
   assign accept     = i_in_valid & o_in_ready & ~i_soft_reset;
   assign last_pix   = accept & (row == ROW_LAST) & (col == COL_LAST);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> RUN on i_run, RUN -> DONE on the last pixel,
   // DONE -> IDLE after one cycle; i_run is ignored outside IDLE.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      state_nxt = state;
      if (i_soft_reset) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (i_run)    state_nxt = ST_RUN;
            ST_RUN:  if (last_pix) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Raster position of the next pixel; cleared when a frame starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (i_soft_reset) begin
         col <= '0;
         row <= '0;
      end else if ((state == ST_IDLE) && i_run) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Line buffer update: each column moves down one row per accepted pixel.
   // NOTE: line buffers are deliberately not reset; stale data from a previous
   // frame is never visible because windows are suppressed until row >= 2.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_top[col] <= lb_mid[col];
         lb_mid[col] <= i_in_pixel;
      end
   end

   // Window shift: drop the leftmost column, load the new right column.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
               win[ky][kx] <= '0;
            end
         end
      end else if (i_soft_reset) begin
         for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
               win[ky][kx] <= '0;
            end
         end
      end else if (accept) begin
         for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
               win[ky][kx] <= win[ky][kx+1];
            end
         end
         win[0][KX-1]    <= lb_top[col];
         win[1][KX-1]    <= lb_mid[col];
         win[KY-1][KX-1] <= i_in_pixel;
      end
   end

   // Window valid: registered one cycle after an accept with a full window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_ot_valid <= 1'b0;
      end else if (i_soft_reset) begin
         o_ot_valid <= 1'b0;
      end else begin
         o_ot_valid <= accept && (row >= ROW_MIN) && (col >= COL_MIN);
      end
   end

   // Pack the window for the MAC: slot ky*KX+kx at [slot*I_F_BW +: I_F_BW].
   always_comb begin
      o_ot_fmap = '0;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX; kx++) begin
            o_ot_fmap[(ky*KX+kx)*I_F_BW +: I_F_BW] = win[ky][kx];
         end
      end
   end

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: scoreboard bench for cnn_window_gen on an 8x8 frame with
// pixel = row*8+col. The driver pushes the expected window, frame-done flag
// and output cycle for every accepted pixel that completes a window; a
// monitor pops and compares whenever o_ot_valid is seen.
module tb_cnn_window_gen;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int BW = 8;
   localparam int FW = 9 * BW;

   localparam logic [FW-1:0] LAST_WIN =
      {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45};

   typedef struct {
      logic [FW-1:0] fmap;
      logic          done;
      int            cyc;
   } exp_t;

   logic            clk;
   logic            reset;
   logic            i_soft_reset;
   logic            i_run;
   logic            i_in_valid;
   logic [BW-1:0]   i_in_pixel;
   logic            o_in_ready;
   logic            o_ot_valid;
   logic [FW-1:0]   o_ot_fmap;
   logic            o_done;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_win    = 0;
   int   cyc      = 0;

   cnn_window_gen #(
      .KX(3), .KY(3), .I_F_BW(BW), .IMG_W(W), .IMG_H(H)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_soft_reset (i_soft_reset),
      .i_run        (i_run),
      .i_in_valid   (i_in_valid),
      .i_in_pixel   (i_in_pixel),
      .o_in_ready   (o_in_ready),
      .o_ot_valid   (o_ot_valid),
      .o_ot_fmap    (o_ot_fmap),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to check output latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pix(input int r, input int c);
      int v;
      v = r * W + c;
      return v[BW-1:0];
   endfunction

   // Expected 3x3 window whose bottom-right pixel is (r, c).
   function automatic logic [FW-1:0] exp_win(input int r, input int c);
      logic [FW-1:0] w;
      w = '0;
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            w[(ky*3+kx)*BW +: BW] = pix(r - 2 + ky, c - 2 + kx);
      return w;
   endfunction

   // Monitor: compare every presented window against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_ot_valid) begin
            n_win++;
            if (sb.size() == 0) begin
               check("unexpected_valid", o_ot_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               check("win_fmap", o_ot_fmap, e.fmap);
               check("win_done", o_done, e.done);
               check("win_cycle", cyc, e.cyc);
            end
         end else if (o_done) begin
            check("done_without_valid", o_done, 1'b0);
         end
      end
   end

   // Present one pixel for one cycle; the DUT is expected to be in RUN.
   task automatic send_pixel(input int r, input int c);
      exp_t e;
      i_in_valid = 1'b1;
      i_in_pixel = pix(r, c);
      if (r >= 2 && c >= 2) begin
         e.fmap = exp_win(r, c);
         e.done = (r == H - 1) && (c == W - 1);
         e.cyc  = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      i_in_valid = 1'b0;
   endtask

   // Start a frame and send n_pix pixels; optional random gaps and an i_run
   // pulse coinciding with pixel index run_at.
   task automatic send_frame(input bit gaps, input int n_pix, input int run_at);
      int w0;
      w0 = n_win;
      i_run = 1'b1;
      @(negedge clk);
      i_run = 1'b0;
      for (int k = 0; k < n_pix; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         if (k == run_at) i_run = 1'b1;
         send_pixel(k / W, k % W);
         i_run = 1'b0;
      end
      if (n_pix == W * H) begin
         @(negedge clk);
         @(negedge clk);
         check("win_count", n_win - w0, (H - 2) * (W - 2));
         check("sb_empty", sb.size(), 0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      i_soft_reset = 1'b0;
      i_run        = 1'b0;
      i_in_valid   = 1'b0;
      i_in_pixel   = '0;
      #12;
      check("rst_ready", o_in_ready, 1'b0);
      check("rst_valid", o_ot_valid, 1'b0);
      check("rst_fmap",  o_ot_fmap,  '0);
      check("rst_done",  o_done,     1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Valid held high in IDLE: nothing accepted, nothing produced.
      i_in_valid = 1'b1;
      i_in_pixel = 8'hAA;
      repeat (5) @(negedge clk);
      check("idle_ready", o_in_ready, 1'b0);
      check("idle_fmap",  o_ot_fmap,  '0);
      i_in_valid = 1'b0;

      // Contiguous frame, then the last window must be held.
      send_frame(1'b0, W * H, -1);
      repeat (3) @(negedge clk);
      check("fmap_hold", o_ot_fmap, LAST_WIN);
      check("idle_done_low", o_done, 1'b0);
      check("idle_ready_after", o_in_ready, 1'b0);

      // Random gaps and an ignored i_run pulse mid-frame.
      send_frame(1'b1, W * H, 30);

      // Soft reset after 20 pixels, with a pixel offered on the same edge.
      send_frame(1'b0, 20, -1);
      i_soft_reset = 1'b1;
      i_in_valid   = 1'b1;
      i_in_pixel   = pix(2, 4);
      @(negedge clk);
      i_soft_reset = 1'b0;
      i_in_valid   = 1'b0;
      check("srst_ready", o_in_ready, 1'b0);
      check("srst_valid", o_ot_valid, 1'b0);
      check("srst_fmap",  o_ot_fmap,  '0);
      check("srst_done",  o_done,     1'b0);
      check("srst_sb_empty", sb.size(), 0);
      send_frame(1'b0, W * H, -1);

      // Asynchronous reset between edges while a window is being presented.
      send_frame(1'b0, 20, -1);
      i_in_valid = 1'b1;
      i_in_pixel = pix(2, 4);
      @(posedge clk);
      #2;
      i_in_valid = 1'b0;
      check("areset_pre_valid", o_ot_valid, 1'b1);
      reset = 1'b1;
      #1;
      check("areset_ready", o_in_ready, 1'b0);
      check("areset_valid", o_ot_valid, 1'b0);
      check("areset_fmap",  o_ot_fmap,  '0);
      check("areset_done",  o_done,     1'b0);
      @(negedge clk);
      reset = 1'b0;
      check("areset_sb_empty", sb.size(), 0);
      send_frame(1'b1, W * H, -1);

      repeat (3) @(negedge clk);
      check("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
